// File: rtl/trng_pkg.sv
// Shared constants and pair-FSM encoding for the TRNG conditioner.
// No logic, no latency.
// No backpressure: type and constant definitions only.
package trng_pkg;

    localparam int TRNG_WIDTH      = 8;
    localparam int TRNG_RCT_CUTOFF = 32;

    typedef enum logic {
        VN_IDLE       = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_e;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs raw bits, emits the first bit of each unequal pair.
// Latency: combinational emit in the cycle the second bit of the pair arrives.
// No backpressure: emitted bits must be taken or dropped by the caller; flush discards a half pair.
module trng_vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_bit,
    input  logic in_valid,
    output logic out_bit,
    output logic out_valid
);
    import trng_pkg::*;

    vn_state_e state_q, state_d;
    logic      first_q, first_d;

    // Pair tracking: remember the first bit, judge the pair on the second.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        out_bit   = 1'b0;
        out_valid = 1'b0;
        if (flush) begin
            state_d = VN_IDLE;
        end else if (in_valid) begin
            case (state_q)
                VN_IDLE: begin
                    first_d = in_bit;
                    state_d = VN_HAVE_FIRST;
                end
                VN_HAVE_FIRST: begin
                    state_d = VN_IDLE;
                    if (first_q != in_bit) begin
                        out_valid = 1'b1;
                        out_bit   = first_q;
                    end
                end
                default: state_d = VN_IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VN_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/trng_conditioner.sv
// Entropy conditioner: repetition-count health test, von Neumann debias, WIDTH-bit word packing.
// Latency: word lands in out_data on the same edge that accepts the sample completing it.
// Backpressure: one full word held in the assembler while output is blocked; later bits dropped with overrun.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int WIDTH      = TRNG_WIDTH,
    parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             raw_bit,
    input  logic             raw_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail,
    input  logic             clear_fail,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]    rct_cnt_q, rct_cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             health_fail_q, health_fail_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             out_free;
    logic             vn_bit, vn_vld;
    logic [WIDTH-1:0] shifted;

    assign accept   = en & raw_valid & ~health_fail_q;
    assign out_free = ~out_valid_q | out_ready;
    assign shifted  = {shift_q[WIDTH-2:0], vn_bit};

    // A disabled or failed conditioner must not complete a half pair later.
    trng_vn_debias u_vn (
        .clk       (clk),
        .rst       (rst),
        .flush     (~en | health_fail_q),
        .in_bit    (raw_bit),
        .in_valid  (accept),
        .out_bit   (vn_bit),
        .out_valid (vn_vld)
    );

    // Health test, word assembly and output register next-state.
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        rct_cnt_d     = rct_cnt_q;
        last_d        = last_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        overrun_d     = 1'b0;

        // Repetition count on raw samples; a zero count marks "no previous sample".
        if (accept) begin
            last_d = raw_bit;
            if (rct_cnt_q == '0 || raw_bit != last_q) begin
                rct_cnt_d = RW'(1);
            end else if (rct_cnt_q != RCT_MAX) begin
                rct_cnt_d = rct_cnt_q + RW'(1);
            end
        end
        health_fail_d = health_fail_q | (rct_cnt_q == RCT_MAX);
        if (clear_fail) begin
            health_fail_d = 1'b0;
            rct_cnt_d     = '0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Gate on the next-state flag so output drops on the same edge the failure registers.
        if (health_fail_d) begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else if (bit_cnt_q == FULL_CNT) begin
            if (out_free) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
                shift_d     = {{(WIDTH-1){1'b0}}, vn_bit};
                bit_cnt_d   = vn_vld ? CW'(1) : '0;
            end else if (vn_vld) begin
                overrun_d = 1'b1;
            end
        end else if (vn_vld) begin
            if (bit_cnt_q == LAST_CNT && out_free) begin
                out_data_d  = shifted;
                out_valid_d = 1'b1;
                shift_d     = '0;
                bit_cnt_d   = '0;
            end else begin
                shift_d   = shifted;
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    // All conditioner state, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            rct_cnt_q     <= '0;
            last_q        <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            rct_cnt_q     <= rct_cnt_d;
            last_q        <= last_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            health_fail_q <= health_fail_d;
            overrun_q     <= overrun_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign health_fail = health_fail_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: table of raw streams plus hand sequences.
// Inputs change 1ns after posedge; outputs are sampled at the same point.
// Summary line reports comparisons made and failures.
module tb_trng_conditioner;

    logic       clk;
    logic       rst;
    logic       en;
    logic       raw_bit;
    logic       raw_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       health_fail;
    logic       clear_fail;
    logic       overrun;

    int checks;
    int errors;
    int vld_seen;
    int ovr_seen;

    typedef struct {
        string       name;
        logic [31:0] pat;
        int          n;
        logic        exp_vld;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs[5];

    trng_conditioner #(.WIDTH(8), .RCT_CUTOFF(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .clear_fail  (clear_fail),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid) vld_seen++;
        if (overrun)   ovr_seen++;
    endtask

    task automatic send(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        vld_seen = 0;
        ovr_seen = 0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        vld_seen   = 0;
        ovr_seen   = 0;
        rst        = 1'b1;
        en         = 1'b1;
        raw_bit    = 1'b0;
        raw_valid  = 1'b0;
        out_ready  = 1'b0;
        clear_fail = 1'b0;

        // Streams are applied MSB-first from bit n-1.
        vecs[0] = '{"pairs_10_01",   32'h0000_9999, 16, 1'b1, 8'hAA};
        vecs[1] = '{"pairs_01_10",   32'h0000_6666, 16, 1'b1, 8'h55};
        vecs[2] = '{"mixed_pairs",   32'h0087_A46E, 24, 1'b1, 8'hB3};
        vecs[3] = '{"seven_bits",    32'h0000_2AAA, 14, 1'b0, 8'h00};
        vecs[4] = '{"all_10",        32'h0000_AAAA, 16, 1'b1, 8'hFF};

        idle(2);
        do_reset();
        chk("rst_out_data",    32'(out_data),    32'h0);
        chk("rst_out_valid",   32'(out_valid),   32'h0);
        chk("rst_health_fail", 32'(health_fail), 32'h0);
        chk("rst_overrun",     32'(overrun),     32'h0);

        // Table: each stream from reset, output always ready.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            out_ready = 1'b1;
            for (int i = 0; i < vecs[r].n; i++) send(vecs[r].pat[vecs[r].n - 1 - i]);
            chk({vecs[r].name, "_valid_cycles"}, 32'(vld_seen), 32'(vecs[r].exp_vld));
            if (vecs[r].exp_vld) chk({vecs[r].name, "_data"}, 32'(out_data), 32'(vecs[r].exp_dat));
            chk({vecs[r].name, "_overrun"}, 32'(ovr_seen), 32'h0);
            idle(1);
            chk({vecs[r].name, "_consumed"}, 32'(out_valid), 32'h0);
        end

        // Runs of four equal bits: no unequal pairs, no health failure.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(1'((i >> 2) & 1));
        chk("runs4_valid_cycles", 32'(vld_seen), 32'h0);
        chk("runs4_health",       32'(health_fail), 32'h0);

        // Blocked output: one word on the port, one in the assembler, 8 dropped bits.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(1'((i + 1) & 1));
        chk("blk_first_word",   32'(out_data),  32'hFF);
        chk("blk_first_valid",  32'(out_valid), 32'h1);
        chk("blk_no_early_ovr", 32'(ovr_seen),  32'h0);
        for (int i = 0; i < 16; i++) send(1'((i + 1) & 1));
        chk("blk_overrun_count", 32'(ovr_seen), 32'h8);
        chk("blk_data_stable",   32'(out_data), 32'hFF);
        out_ready = 1'b1;
        idle(1);
        chk("blk_second_valid", 32'(out_valid), 32'h1);
        chk("blk_second_word",  32'(out_data),  32'hFF);
        idle(1);
        chk("blk_drained", 32'(out_valid), 32'h0);

        // Health failure discards a held word and blocks input until cleared.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(1'((i + 1) & 1));
        chk("hf_word_held", 32'(out_valid), 32'h1);
        for (int i = 0; i < 32; i++) send(1'b1);
        idle(1);
        chk("hf_flag",       32'(health_fail), 32'h1);
        chk("hf_valid_drop", 32'(out_valid),   32'h0);
        out_ready = 1'b1;
        vld_seen  = 0;
        for (int i = 0; i < 16; i++) send(1'(i & 1));
        chk("hf_ignored",  32'(vld_seen),    32'h0);
        chk("hf_sticky",   32'(health_fail), 32'h1);
        clear_fail = 1'b1;
        idle(1);
        clear_fail = 1'b0;
        chk("hf_cleared", 32'(health_fail), 32'h0);
        for (int i = 0; i < 16; i++) send(1'(i & 1));
        chk("hf_after_valid", 32'(out_valid), 32'h1);
        chk("hf_after_data",  32'(out_data),  32'h00);

        // clear_fail on the cycle of the failing sample wins.
        do_reset();
        for (int i = 0; i < 31; i++) send(1'b1);
        clear_fail = 1'b1;
        send(1'b1);
        clear_fail = 1'b0;
        idle(2);
        chk("clr_wins", 32'(health_fail), 32'h0);

        // Disabling mid-pair drops the half pair.
        do_reset();
        out_ready = 1'b1;
        send(1'b1);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        send(1'b0);
        send(1'b1);
        for (int i = 0; i < 14; i++) send(1'((i + 1) & 1));
        chk("en_half_pair_valid", 32'(out_valid), 32'h1);
        chk("en_half_pair_data",  32'(out_data),  32'h7F);

        // Reset mid-word discards partial bits.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(1'(i & 1));
        do_reset();
        for (int i = 0; i < 16; i++) send(1'((i + 1) & 1));
        chk("rst_mid_valid_cycles", 32'(vld_seen), 32'h1);
        chk("rst_mid_data",         32'(out_data), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
